not16_byte_serial: RTL
======================

# not16_byte_serial

Byte-serial 16-bit bitwise inverter. Accepts a 16-bit word on a valid/ready input port and emits its complement as two 8-bit beats on a valid/ready output port, tagging the final beat with `out_last`. It is the time-multiplexed counterpart of the parallel 16-bit NOT path: one 8-bit NOT slice is reused across two cycles. It feeds the 8-bit peripheral bus from the 16-bit ALU datapath.

## Interface

- `LOW_FIRST`, default 1: 1 emits bits [7:0] first; 0 emits bits [15:8] first.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `in_data` input 16: word to invert.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts the word this cycle.
- `out_data` output 8: inverted byte.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the sink accepts the beat this cycle.
- `out_last` output 1: the current beat is the second byte of the word.

## Operation

- A transfer occurs on a port in any cycle where both valid and ready are high at the rising edge of `clk`.
- The input handshake captures `in_data` into a 16-bit holding register `word`.
- The state machine has three states: IDLE, FIRST, SECOND.
  - **IDLE**
    - `in_ready`=1, `out_valid`=0.
    - On an input transfer, capture the word and go to FIRST.
  - **FIRST**
    - `out_valid`=1, `out_last`=0.
    - `out_data` = ~`word`[7:0] if `LOW_FIRST`, else ~`word`[15:8].
    - On an output transfer, go to SECOND. Otherwise hold.
  - **SECOND**
    - `out_valid`=1, `out_last`=1, `out_data` is the other byte, inverted.
    - On an output transfer, go to IDLE. For the skid case, see Configuration.
- `out_data` is forced to 8'h00 whenever `out_valid`=0.
- `word` changes only on an input transfer. It is never modified by output beats.
- Valid/ready rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer.
  - `in_ready` does not depend on `in_valid`.
- Reset mid-operation: any pending beats are discarded and the block returns to IDLE. No partial word is resumed.

## Timing

- Reset values: state=IDLE, `word`=16'h0000, `in_ready`=1, `out_valid`=0, `out_data`=8'h00, `out_last`=0.
- Latency: first beat is valid in the cycle after the input transfer. Second beat is valid in the cycle after the first-beat transfer, provided `out_ready` is held high.
- Throughput without the skid option: one word per 3 cycles when `out_ready`=1 continuously.
- Back-pressure: each held-off beat adds one cycle. `in_ready` stays 0 throughout FIRST and SECOND.
- `in_ready` and `out_valid` are decoded combinationally from state only, with the one exception listed under Configuration.

## Configuration

- `NOT16_SKID_EN` defined:
  - In SECOND, `in_ready` = `out_ready`.
  - A simultaneous final-beat transfer and input transfer loads the new word and goes directly to FIRST.
  - Sustained throughput is one word per 2 cycles with no idle gap.
  - SECOND with an output transfer and no input transfer goes to IDLE.
- `NOT16_SKID_EN` undefined:
  - `in_ready` is 0 in FIRST and SECOND.
  - The block always passes through IDLE between words.

## Structure

- Shared include file `not16_byte_serial_defs.vh` holds the 2-bit state encodings: IDLE=2'd0, FIRST=2'd1, SECOND=2'd2. State 2'd3 is illegal and recovers to IDLE on the next clock.
- One sub-module: instantiate the existing 8-bit NOT block once. Its input is a 2:1 mux of `word` bytes selected by state and `LOW_FIRST`.

## Test plan

- **Reset check:** assert `reset` asynchronously mid-cycle -> outputs take reset values immediately. After release: `in_ready`=1, `out_valid`=0.
- **Basic word:** `in_data`=16'h0012, `LOW_FIRST`=1, `out_ready`=1 -> beats 8'hED (`out_last`=0) then 8'hFF (`out_last`=1) on consecutive cycles. Then IDLE.
- **Beat order:** `in_data`=16'h3CAA, `LOW_FIRST`=0 -> beats 8'hC3 then 8'h55 (`last`). With `in_data`=16'hFFFF -> 8'h00, 8'h00.
- **Back-pressure:** hold `out_ready`=0 for 4 cycles in FIRST with `in_data`=16'h00FF -> 8'h00 held stable, `in_ready`=0. Then beats 8'h00 and 8'hFF.
- **Streaming:** stream 16'h0000, 16'hFFFF, 16'h1234 with `in_valid`=1 and `out_ready`=1.
  - With `NOT16_SKID_EN`: 6 contiguous beats FF, FF, 00, 00, CB, ED.
  - Without it: one idle cycle between words.
- **Reset mid-word:** pulse `reset` during SECOND -> no further beats. The next word is processed cleanly.

Source files
------------

// File: rtl/not16_byte_serial_pkg.sv
// not16_byte_serial_pkg: shared state encodings and byte-select helper for the
// byte-serial 16-bit inverter. State 2'd3 is unused and decodes back to IDLE.
package not16_byte_serial_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  // Pick the high or low byte of a 16-bit word.
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic high);
    select_byte = high ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/not16_byte_serial_if.sv
// not16_byte_serial_if: valid/ready word input and byte output of the
// byte-serial inverter. The slave modport is the block, master is its
// environment (word producer plus byte sink).
interface not16_byte_serial_if;

  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/not16_byte_serial_not8.sv
// not16_byte_serial_not8: the 8-bit NOT slice reused for both bytes of a word.
module not16_byte_serial_not8 (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Plain bitwise complement of one byte.
  always_comb begin
    y = ~a;
  end

endmodule

// File: rtl/not16_byte_serial.sv
// not16_byte_serial: accepts a 16-bit word and emits its complement as two
// 8-bit beats, the second tagged with out_last. LOW_FIRST selects which byte
// goes out first.
// Optional feature macro NOT16_SKID_EN: accept the next word during the final
// beat so words stream back to back without passing through IDLE.
module not16_byte_serial
  import not16_byte_serial_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  not16_byte_serial_if.slave      bus
);

  logic [1:0]  state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        in_xfer;
  logic        out_xfer;
  logic        sel_high;
  logic [7:0]  slice_in;
  logic [7:0]  slice_out;

  // Handshake outputs are decoded from state; only the skid path adds out_ready.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
      end
      ST_FIRST: begin
        bus.out_valid = 1'b1;
      end
      ST_SECOND: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
`ifdef NOT16_SKID_EN
        bus.in_ready  = bus.out_ready;
`endif
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

  // Choose which byte of the held word feeds the shared NOT slice.
  always_comb begin
    sel_high = 1'b0;
    if (state_q == ST_FIRST) begin
      sel_high = !LOW_FIRST;
    end else if (state_q == ST_SECOND) begin
      sel_high = LOW_FIRST;
    end
    slice_in = select_byte(word_q, sel_high);
  end

  not16_byte_serial_not8 u_not8 (
    .a (slice_in),
    .y (slice_out)
  );

  // Output byte is zero whenever no beat is being offered.
  always_comb begin
    bus.out_data = bus.out_valid ? slice_out : 8'h00;
  end

  // Next-state and word capture; the word only changes on an input transfer.
  always_comb begin
    in_xfer  = bus.in_valid && bus.in_ready;
    out_xfer = bus.out_valid && bus.out_ready;
    word_d   = in_xfer ? bus.in_data : word_q;
    state_d  = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          state_d = ST_FIRST;
        end
      end
      ST_FIRST: begin
        if (out_xfer) begin
          state_d = ST_SECOND;
        end
      end
      ST_SECOND: begin
        if (out_xfer) begin
          state_d = in_xfer ? ST_FIRST : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and holding register; reset discards any partially sent word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

endmodule
